shared_approx_arbiter: RTL and testbench
========================================

Name: shared_approx_arbiter

Overview:
- Round-robin arbiter and two-stage pipeline that time-shares one operand-decomposition unit (`shared_approx_units`) among N_REQ requesters.
- Each requester offers a signed operand on a valid/ready handshake.
- The block returns the decomposed triple (mult_a_in, a_sign, a_shamt) tagged with the requester ID on a single valid/ready output port.
- It sits between the PE operand fetch logic and the approximate multiplier array.

Parameters:
- N_REQ, 4, number of requesters (>=2).
- MULT_DW, 4, accurate multiplier width; passed to the decomposition unit.
- A_BW, 8, operand width in bits (>= MULT_DW+1).
- ID_W, $clog2(N_REQ), requester ID width.

Ports:
- clk  in  1  clock; rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of pipeline contents and arbiter pointer.
- req_valid  in  N_REQ  per-requester operand valid.
- req_ready  out  N_REQ  per-requester accept; at most one bit high per cycle.
- req_a  in  N_REQ*A_BW  flattened operands; requester i occupies bits [i*A_BW +: A_BW].
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- out_id  out  ID_W  index of the requester that owns the result.
- out_mult_a_in  out  MULT_DW  multiplier input.
- out_a_sign  out  1  operand sign.
- out_a_shamt  out  $clog2(A_BW)  shift amount.
- busy  out  1  high when any stage holds data.

Behaviour:
- Reset (rst_n=0, asynchronous): s1_valid=0, s2_valid=0, rr_ptr=0. All out_* registers = 0. req_ready = 0, busy = 0.
- Arbiter:
  - Grant goes to the first i with req_valid[i]=1, searching i = rr_ptr, rr_ptr+1, ... modulo N_REQ.
  - grant is one-hot or zero. req_ready = grant & {N_REQ{s1_adv_ok}}.
  - req_ready may depend combinationally on req_valid. No other combinational input-to-output paths exist.
  - On a handshake (req_valid[g] & req_ready[g]), rr_ptr <= (g+1) mod N_REQ. Without a handshake, rr_ptr holds.
- Pipeline:
  - S1 registers the operand and ID. The decomposition unit is combinational on the S1 operand. S2 registers the decomposed result and ID, which drive out_*.
  - s2_adv_ok = !s2_valid | out_ready.
  - s1_adv_ok = !s1_valid | s2_adv_ok.
  - S1 moves into S2 when s1_valid & s2_adv_ok.
- Latency: accept edge at cycle 0 gives out_valid=1 after the cycle-2 edge with no stall. Sustained throughput is 1 result/cycle.
- Output stability: while out_valid=1 & out_ready=0, all out_* hold stable and no upstream data is lost. A full pipeline stalls, forcing req_ready=0.
- Decomposition contract (checked by the bench):
  - uns = |a| in A_BW bits; the most negative value maps to 2^(A_BW-1).
  - L = index of the leading one of uns; L = 0 when uns = 0.
  - If L > MULT_DW-1: shamt = L-(MULT_DW-1) and mult_a_in = {1, uns[L-1 -: MULT_DW-2], 1}.
  - Otherwise: shamt = 0 and mult_a_in = uns[MULT_DW-1:0].
  - a_sign = a[A_BW-1].
- Boundaries:
  - All requesters valid: strict rotation, each served once per N_REQ grants.
  - Single requester streaming: served every cycle.
  - rr_ptr wraps from N_REQ-1 to 0.
  - flush=1: next edge clears s1_valid, s2_valid and rr_ptr; req_ready=0 that cycle; in-flight results are dropped. flush takes priority over a simultaneous handshake.
  - Reset mid-transfer: data is discarded and outputs return to reset values immediately.
  - busy = s1_valid | s2_valid.

Optional Feature:
- Macro: SAU_GRANT_CNT_EN.
- When defined: adds output grant_cnt (N_REQ*16 bits, flattened). Each 16-bit counter increments on its requester's handshake and saturates at 16'hFFFF. Counters clear on reset and on flush.
- When undefined: port and logic are absent; all other behaviour is identical.

Test Plan (N_REQ=4, MULT_DW=4, A_BW=8):
- Requester 0 sends a=8'd100, out_ready=1 → 2 cycles later: out_valid=1, id=0, mult_a_in=4'b1101, sign=0, shamt=3.
- Requester 2 sends a=8'h9C (-100), then requester 1 sends 8'h80 (-128) → id=2 {1101,1,3}, then id=1 {1001,1,4}.
- a=8'd5 and a=8'd0 → {0101,0,0} and {0000,0,0}.
- All four requesters valid continuously for 8 grants → grant order 0,1,2,3,0,1,2,3; each req_ready pulse is one-hot.
- out_ready=0 for 5 cycles with all requesters valid → two results buffered, req_ready=0 after 2 accepts, out_* stable. Release → results in order with no loss or duplication.
- flush during stall, then rst_n=0 mid-stream → busy=0, out_valid=0, rr_ptr=0. The next grant goes to the lowest valid index. With SAU_GRANT_CNT_EN defined, counters read 0.

Source files
------------

// File: rtl/shared_approx_arbiter_if.sv
// rtl/shared_approx_arbiter_if.sv - requester and result handshake bundle for shared_approx_arbiter
interface shared_approx_arbiter_if #(
    parameter int N_REQ   = 4,
    parameter int MULT_DW = 4,
    parameter int A_BW    = 8,
    parameter int ID_W    = $clog2(N_REQ)
);
    logic [N_REQ-1:0]         req_valid;
    logic [N_REQ-1:0]         req_ready;
    logic [N_REQ*A_BW-1:0]    req_a;
    logic                     out_valid;
    logic                     out_ready;
    logic [ID_W-1:0]          out_id;
    logic [MULT_DW-1:0]       out_mult_a_in;
    logic                     out_a_sign;
    logic [$clog2(A_BW)-1:0]  out_a_shamt;

    modport slave (
        input  req_valid, req_a, out_ready,
        output req_ready, out_valid, out_id, out_mult_a_in, out_a_sign, out_a_shamt
    );

    modport master (
        output req_valid, req_a, out_ready,
        input  req_ready, out_valid, out_id, out_mult_a_in, out_a_sign, out_a_shamt
    );
endinterface

// File: rtl/shared_approx_arbiter.sv
// rtl/shared_approx_arbiter.sv - round-robin arbiter + 2-stage pipeline around one operand decomposition unit
// Optional per-requester grant counters enabled by defining SAU_GRANT_CNT_EN.
module shared_approx_units #(
    parameter int A_BW    = 8,
    parameter int MULT_DW = 4
) (
    input  logic [A_BW-1:0]          a,
    output logic [MULT_DW-1:0]       mult_a_in,
    output logic                     a_sign,
    output logic [$clog2(A_BW)-1:0]  a_shamt
);
    localparam int SW = $clog2(A_BW);

    logic [A_BW-1:0]      uns;
    logic [SW-1:0]        lead;
    logic [MULT_DW-3:0]   mid;

    // Magnitude wraps naturally so the most negative value becomes 2^(A_BW-1).
    always_comb begin
        uns       = a[A_BW-1] ? (~a + 1'b1) : a;
        lead      = '0;
        mid       = '0;
        mult_a_in = '0;
        a_shamt   = '0;
        a_sign    = a[A_BW-1];
        for (int i = 0; i < A_BW; i++) begin
            if (uns[i]) lead = SW'(i);
        end
        if (lead > SW'(MULT_DW-1)) begin
            a_shamt   = lead - SW'(MULT_DW-1);
            mid       = (MULT_DW-2)'(uns >> (lead - SW'(MULT_DW-2)));
            mult_a_in = {1'b1, mid, 1'b1};
        end else begin
            mult_a_in = uns[MULT_DW-1:0];
        end
    end
endmodule

module shared_approx_arbiter #(
    parameter int N_REQ   = 4,
    parameter int MULT_DW = 4,
    parameter int A_BW    = 8,
    parameter int ID_W    = $clog2(N_REQ)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    shared_approx_arbiter_if.slave      bus,
`ifdef SAU_GRANT_CNT_EN
    output logic [N_REQ*16-1:0]         grant_cnt,
`endif
    output logic                        busy
);
    localparam int SW = $clog2(A_BW);

    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    g_idx;
    logic [ID_W-1:0]    cand;
    logic [ID_W-1:0]    rr_next;
    logic [N_REQ-1:0]   grant;
    logic               grant_any;
    logic               hs;

    logic               s1_valid;
    logic [A_BW-1:0]    s1_a;
    logic [ID_W-1:0]    s1_id;
    logic               s2_valid;
    logic               s1_adv_ok;
    logic               s2_adv_ok;

    logic [MULT_DW-1:0] d_mult;
    logic               d_sign;
    logic [SW-1:0]      d_shamt;

    assign s2_adv_ok = !s2_valid | bus.out_ready;
    assign s1_adv_ok = !s1_valid | s2_adv_ok;

    always_comb begin
        g_idx     = '0;
        cand      = '0;
        grant_any = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = ID_W'((int'(rr_ptr) + k) % N_REQ);
            if (!grant_any && bus.req_valid[cand]) begin
                grant_any = 1'b1;
                g_idx     = cand;
            end
        end
        grant = grant_any ? (N_REQ'(1) << g_idx) : '0;
    end

    // flush and reset both suppress acceptance so nothing enters a pipeline being cleared.
    assign bus.req_ready = grant & {N_REQ{s1_adv_ok & !flush & rst_n}};
    assign hs            = |bus.req_ready;
    assign rr_next       = (g_idx == ID_W'(N_REQ-1)) ? '0 : g_idx + 1'b1;
    assign busy          = s1_valid | s2_valid;
    assign bus.out_valid = s2_valid;

    shared_approx_units #(.A_BW(A_BW), .MULT_DW(MULT_DW)) u_units (
        .a         (s1_a),
        .mult_a_in (d_mult),
        .a_sign    (d_sign),
        .a_shamt   (d_shamt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr            <= '0;
            s1_valid          <= 1'b0;
            s1_a              <= '0;
            s1_id             <= '0;
            s2_valid          <= 1'b0;
            bus.out_id        <= '0;
            bus.out_mult_a_in <= '0;
            bus.out_a_sign    <= 1'b0;
            bus.out_a_shamt   <= '0;
        end else if (flush) begin
            rr_ptr   <= '0;
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s2_adv_ok) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    bus.out_id        <= s1_id;
                    bus.out_mult_a_in <= d_mult;
                    bus.out_a_sign    <= d_sign;
                    bus.out_a_shamt   <= d_shamt;
                end
            end
            if (s1_adv_ok) begin
                s1_valid <= hs;
                if (hs) begin
                    s1_a   <= bus.req_a[int'(g_idx)*A_BW +: A_BW];
                    s1_id  <= g_idx;
                    rr_ptr <= rr_next;
                end
            end
        end
    end

`ifdef SAU_GRANT_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt <= '0;
        end else if (flush) begin
            grant_cnt <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (hs && g_idx == ID_W'(i) && grant_cnt[i*16 +: 16] != 16'hFFFF)
                    grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_shared_approx_arbiter.sv
// tb/tb_shared_approx_arbiter.sv - directed self-checking bench for shared_approx_arbiter
module tb_shared_approx_arbiter;
    localparam int N_REQ   = 4;
    localparam int MULT_DW = 4;
    localparam int A_BW    = 8;
    localparam int ID_W    = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic busy;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    shared_approx_arbiter_if #(.N_REQ(N_REQ), .MULT_DW(MULT_DW), .A_BW(A_BW), .ID_W(ID_W)) bus ();

`ifdef SAU_GRANT_CNT_EN
    logic [N_REQ*16-1:0] grant_cnt;
`endif

    shared_approx_arbiter #(.N_REQ(N_REQ), .MULT_DW(MULT_DW), .A_BW(A_BW), .ID_W(ID_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus.slave),
`ifdef SAU_GRANT_CNT_EN
        .grant_cnt (grant_cnt),
`endif
        .busy  (busy)
    );

    // {valid, id, mult_a_in, sign, shamt}
    function automatic logic [10:0] obs();
        return {bus.out_valid, bus.out_id, bus.out_mult_a_in, bus.out_a_sign, bus.out_a_shamt};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input int i, input logic [7:0] v);
        bus.req_a[i*8 +: 8] = v;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req_a = '0;
        bus.out_ready = 1'b0;
        bus.req_valid = 4'hF;
        #1;
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b expected %b", bus.req_ready, 4'b0000); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected %b", busy, 1'b0); end
        checks++; if (obs() !== 11'h000) begin errors++; $display("FAIL reset_out: got %h expected %h", obs(), 11'h000); end
        tick();
        tick();
        rst_n = 1'b1;
        bus.req_valid = 4'h0;
        tick();
    endtask

    task automatic test_single();
        set_a(0, 8'd100);
        bus.out_ready = 1'b1;
        bus.req_valid = 4'b0001;
        #1;
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b expected %b", bus.req_ready, 4'b0001); end
        tick();
        bus.req_valid = 4'b0000;
        checks++; if ({bus.out_valid, busy} !== 2'b01) begin errors++; $display("FAIL single_s1: got %b expected %b", {bus.out_valid, busy}, 2'b01); end
        tick();
        checks++; if (obs() !== {1'b1, 2'd0, 4'b1101, 1'b0, 3'd3}) begin errors++; $display("FAIL single_out: got %h expected %h", obs(), {1'b1, 2'd0, 4'b1101, 1'b0, 3'd3}); end
        tick();
        checks++; if ({bus.out_valid, busy} !== 2'b00) begin errors++; $display("FAIL single_drain: got %b expected %b", {bus.out_valid, busy}, 2'b00); end
    endtask

    task automatic test_negative();
        set_a(2, 8'h9C);
        set_a(1, 8'h80);
        bus.req_valid = 4'b0100;
        #1;
        checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL neg_ready2: got %b expected %b", bus.req_ready, 4'b0100); end
        tick();
        bus.req_valid = 4'b0010;
        #1;
        checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL neg_ready1_wrap: got %b expected %b", bus.req_ready, 4'b0010); end
        tick();
        bus.req_valid = 4'b0000;
        checks++; if (obs() !== {1'b1, 2'd2, 4'b1101, 1'b1, 3'd3}) begin errors++; $display("FAIL neg_out_m100: got %h expected %h", obs(), {1'b1, 2'd2, 4'b1101, 1'b1, 3'd3}); end
        tick();
        checks++; if (obs() !== {1'b1, 2'd1, 4'b1001, 1'b1, 3'd4}) begin errors++; $display("FAIL neg_out_m128: got %h expected %h", obs(), {1'b1, 2'd1, 4'b1001, 1'b1, 3'd4}); end
        tick();
    endtask

    task automatic test_small_stream();
        set_a(0, 8'd5);
        bus.req_valid = 4'b0001;
        #1;
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL stream_ready0: got %b expected %b", bus.req_ready, 4'b0001); end
        tick();
        set_a(0, 8'd0);
        #1;
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL stream_ready1: got %b expected %b", bus.req_ready, 4'b0001); end
        tick();
        bus.req_valid = 4'b0000;
        checks++; if (obs() !== {1'b1, 2'd0, 4'b0101, 1'b0, 3'd0}) begin errors++; $display("FAIL small_out5: got %h expected %h", obs(), {1'b1, 2'd0, 4'b0101, 1'b0, 3'd0}); end
        tick();
        checks++; if (obs() !== {1'b1, 2'd0, 4'b0000, 1'b0, 3'd0}) begin errors++; $display("FAIL small_out0: got %h expected %h", obs(), {1'b1, 2'd0, 4'b0000, 1'b0, 3'd0}); end
        tick();
    endtask

    task automatic test_rotation();
        logic [3:0] exp_r;
        logic [1:0] exp_id;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        set_a(0, 8'd10); set_a(1, 8'd20); set_a(2, 8'd30); set_a(3, 8'd40);
        bus.req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            #1;
            exp_r = 4'b0001 << (k % 4);
            checks++; if (bus.req_ready !== exp_r) begin errors++; $display("FAIL rot_ready[%0d]: got %b expected %b", k, bus.req_ready, exp_r); end
            tick();
            if (k >= 1) begin
                exp_id = 2'((k - 1) % 4);
                checks++; if ({bus.out_valid, bus.out_id} !== {1'b1, exp_id}) begin errors++; $display("FAIL rot_out[%0d]: got %b expected %b", k, {bus.out_valid, bus.out_id}, {1'b1, exp_id}); end
            end
        end
        bus.req_valid = 4'h0;
        tick();
        checks++; if ({bus.out_valid, bus.out_id} !== 3'b111) begin errors++; $display("FAIL rot_last: got %b expected %b", {bus.out_valid, bus.out_id}, 3'b111); end
        tick();
    endtask

    task automatic test_stall();
        set_a(0, 8'd100);
        set_a(1, 8'h80);
        bus.out_ready = 1'b0;
        bus.req_valid = 4'hF;
        #1;
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL stall_acc0: got %b expected %b", bus.req_ready, 4'b0001); end
        tick();
        #1;
        checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL stall_acc1: got %b expected %b", bus.req_ready, 4'b0010); end
        tick();
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL stall_ready[%0d]: got %b expected %b", c, bus.req_ready, 4'b0000); end
            checks++; if (obs() !== {1'b1, 2'd0, 4'b1101, 1'b0, 3'd3}) begin errors++; $display("FAIL stall_hold[%0d]: got %h expected %h", c, obs(), {1'b1, 2'd0, 4'b1101, 1'b0, 3'd3}); end
            tick();
        end
        bus.out_ready = 1'b1;
        bus.req_valid = 4'h0;
        tick();
        checks++; if (obs() !== {1'b1, 2'd1, 4'b1001, 1'b1, 3'd4}) begin errors++; $display("FAIL stall_release: got %h expected %h", obs(), {1'b1, 2'd1, 4'b1001, 1'b1, 3'd4}); end
        tick();
        checks++; if ({bus.out_valid, busy} !== 2'b00) begin errors++; $display("FAIL stall_drain: got %b expected %b", {bus.out_valid, busy}, 2'b00); end
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        bus.req_valid = 4'hF;
        #1;
        checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL flush_pre: got %b expected %b", bus.req_ready, 4'b0100); end
        tick();
        flush = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL flush_ready: got %b expected %b", bus.req_ready, 4'b0000); end
        tick();
        flush = 1'b0;
        bus.req_valid = 4'b1010;
        checks++; if ({busy, bus.out_valid, dut.rr_ptr} !== 4'b0000) begin errors++; $display("FAIL flush_state: got %b expected %b", {busy, bus.out_valid, dut.rr_ptr}, 4'b0000); end
        #1;
        checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL flush_next_grant: got %b expected %b", bus.req_ready, 4'b0010); end
        tick();
        bus.req_valid = 4'h0;
        bus.out_ready = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b1;
        bus.req_valid = 4'hF;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({busy, bus.out_valid, dut.rr_ptr} !== 4'b0000) begin errors++; $display("FAIL rstmid_state: got %b expected %b", {busy, bus.out_valid, dut.rr_ptr}, 4'b0000); end
        checks++; if (obs() !== 11'h000) begin errors++; $display("FAIL rstmid_out: got %h expected %h", obs(), 11'h000); end
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL rstmid_ready: got %b expected %b", bus.req_ready, 4'b0000); end
`ifdef SAU_GRANT_CNT_EN
        checks++; if (grant_cnt !== '0) begin errors++; $display("FAIL rstmid_cnt: got %h expected 0", grant_cnt); end
`endif
        tick();
        rst_n = 1'b1;
        bus.req_valid = 4'b1100;
        #1;
        checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL rstmid_grant: got %b expected %b", bus.req_ready, 4'b0100); end
        tick();
        bus.req_valid = 4'h0;
        tick();
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_negative();
        test_small_stream();
        test_rotation();
        test_stall();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
